// File: rtl/divider_sched_pkg.sv
// -----------------------------------------------------------------------------
// divider_sched_pkg
//   Shared types and helpers for the round-robin divider scheduler.
//   - div_tag_t : per-slot tag travelling alongside each issued division
//   - calc_idw  : requester index width (at least 1 bit)
//   - rr_next   : round-robin successor of an index
// -----------------------------------------------------------------------------
package divider_sched_pkg;

    // Tag id field is sized for the largest supported requester count;
    // the scheduler only ever writes the low calc_idw(NUM_REQ) bits.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
        logic                dbz;
    } div_tag_t;

    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request found when
//   scanning ptr, ptr+1, ... (mod NUM_REQ).
// Ports
//   req    in   NUM_REQ  request vector
//   ptr    in   IDW      highest-priority index this cycle
//   grant  out  NUM_REQ  one-hot winner (all zero when no request)
//   winner out  IDW      winner index (0 when no request)
//   any    out  1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import divider_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = calc_idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_rr_scheduler.sv
// -----------------------------------------------------------------------------
// divider_rr_scheduler
//   Shares one pipelined unsigned divider among NUM_REQ requesters. One
//   request is granted per cycle in round-robin order and issued straight to
//   the divider; a tag pipeline of DIV_LATENCY stages follows each op so the
//   returning quotient/remainder is steered back to its originator.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/ready/a/b      requester side (a/b packed, slice i = requester i)
//   rsp_valid/q/r/dbz        one-hot result strobe + shared result bus
//   div_i_valid/a/b          to divider inputs
//   div_o_valid/q/r          from divider outputs
//   drain                    stop granting new requests
//   idle                     drain active and nothing in flight
//   inflight                 ops issued but not yet returned
//   err                      sticky divider-valid vs tag-valid mismatch
// -----------------------------------------------------------------------------
module divider_rr_scheduler
    import divider_sched_pkg::*;
#(
    parameter  int DATAWIDTH   = 8,
    parameter  int NUM_REQ     = 4,
    parameter  int DIV_LATENCY = 1,
    localparam int IDW         = calc_idw(NUM_REQ),
    localparam int IW          = $clog2(DIV_LATENCY + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_q,
    output logic [DATAWIDTH-1:0]           rsp_r,
    output logic                           rsp_dbz,
    output logic                           div_i_valid,
    output logic [DATAWIDTH-1:0]           div_a,
    output logic [DATAWIDTH-1:0]           div_b,
    input  logic                           div_o_valid,
    input  logic [DATAWIDTH-1:0]           div_q,
    input  logic [DATAWIDTH-1:0]           div_r,
    input  logic                           drain,
    output logic                           idle,
    output logic [IW-1:0]                  inflight,
    output logic                           err
);

    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       winner;
    logic [NUM_REQ-1:0]   grant;
    logic                 any_req;
    logic                 accept;
    logic                 retire;
    logic [DATAWIDTH-1:0] a_sel, b_sel;
    logic [DATAWIDTH-1:0] a_hold, b_hold;
    logic [IW-1:0]        warm;
    logic [IW-1:0]        inflight_nxt;
    div_tag_t             tags [DIV_LATENCY];
    div_tag_t             tag_in;
    div_tag_t             tag_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any_req)
    );

    assign accept    = rst && !drain && any_req;
    assign req_ready = (rst && !drain) ? grant : '0;

    assign a_sel = req_a[winner*DATAWIDTH +: DATAWIDTH];
    assign b_sel = req_b[winner*DATAWIDTH +: DATAWIDTH];

    // Divider operands hold their last issued values between accepts.
    assign div_i_valid = accept;
    assign div_a       = accept ? a_sel : a_hold;
    assign div_b       = accept ? b_sel : b_hold;

    always_comb begin
        tag_in     = '0;
        tag_in.v   = accept;
        tag_in.id  = TAG_ID_W'(winner);
        tag_in.dbz = (b_sel == '0);
    end

    assign tag_last = tags[DIV_LATENCY-1];
    assign retire   = tag_last.v;

    // Results for ops caught by a reset are suppressed in the reset cycle too.
    assign rsp_valid = (rst && tag_last.v) ? (NUM_REQ'(1) << tag_last.id) : '0;
    assign rsp_dbz   = rst && tag_last.v && tag_last.dbz;
    assign rsp_q     = div_q;
    assign rsp_r     = div_r;

    always_comb begin
        case ({accept, retire})
            2'b10:   inflight_nxt = inflight + 1'b1;
            2'b01:   inflight_nxt = inflight - 1'b1;
            default: inflight_nxt = inflight;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            for (int k = 0; k < DIV_LATENCY; k++) tags[k] <= '0;
            inflight <= '0;
            err      <= 1'b0;
            warm     <= IW'(DIV_LATENCY);
            idle     <= 1'b0;
            a_hold   <= '0;
            b_hold   <= '0;
        end else begin
            if (accept) begin
                ptr    <= IDW'(rr_next(int'(winner), NUM_REQ));
                a_hold <= a_sel;
                b_hold <= b_sel;
            end
            tags[0] <= tag_in;
            for (int k = 1; k < DIV_LATENCY; k++) tags[k] <= tags[k-1];
            inflight <= inflight_nxt;
            // Divider outputs left over from before reset are not checked
            // until the tag pipeline has refilled.
            if (warm != '0) begin
                warm <= warm - 1'b1;
            end else if (div_o_valid != tag_last.v) begin
                err <= 1'b1;
            end
            idle <= drain && (inflight_nxt == '0);
        end
    end

endmodule

// File: tb/tb_divider_rr_scheduler.sv
module tb_divider_rr_scheduler;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int L  = 3;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid, req_ready, rsp_valid;
    logic [NR*DW-1:0]   req_a, req_b;
    logic [DW-1:0]      rsp_q, rsp_r, div_a, div_b, div_q, div_r;
    logic               rsp_dbz, div_i_valid, div_o_valid, drain, idle, err;
    logic [IW-1:0]      inflight;
    logic               force_ov;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divider_rr_scheduler #(.DATAWIDTH(DW), .NUM_REQ(NR), .DIV_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz),
        .div_i_valid(div_i_valid), .div_a(div_a), .div_b(div_b),
        .div_o_valid(div_o_valid), .div_q(div_q), .div_r(div_r),
        .drain(drain), .idle(idle), .inflight(inflight), .err(err)
    );

    // External pipelined divider model (no reset, so stale results survive a scheduler reset).
    logic          dv_v [L];
    logic [DW-1:0] dv_q [L];
    logic [DW-1:0] dv_r [L];

    initial for (int k = 0; k < L; k++) dv_v[k] = 1'b0;

    always @(posedge clk) begin
        dv_v[0] <= div_i_valid;
        dv_q[0] <= (div_b == '0) ? '1 : div_a / div_b;
        dv_r[0] <= (div_b == '0) ? '1 : div_a % div_b;
        for (int k = 1; k < L; k++) begin
            dv_v[k] <= dv_v[k-1];
            dv_q[k] <= dv_q[k-1];
            dv_r[k] <= dv_r[k-1];
        end
    end

    assign div_o_valid = dv_v[L-1] | force_ov;
    assign div_q       = dv_q[L-1];
    assign div_r       = dv_r[L-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard
    typedef struct {
        int            id;
        int            due;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t sbq[$];
    int   cyc     = 0;
    int   ptr_m   = 0;
    int   warm_m  = L;
    bit   started = 0;
    logic idle_m  = 1'b0;
    logic err_m   = 1'b0;

    always @(negedge clk) begin
        logic          tag_v;
        logic [NR-1:0] exp_rsp, exp_ready;
        bit            acc;
        int            win;
        logic [DW-1:0] a_w, b_w;
        exp_t          e;

        if (started) begin
            chk("inflight", 32'(inflight), 32'(sbq.size()));
            chk("idle", 32'(idle), 32'(idle_m));
            chk("err", 32'(err), 32'(err_m));
        end

        tag_v   = (sbq.size() > 0) && (sbq[0].due == cyc);
        exp_rsp = '0;
        if (rst && tag_v) exp_rsp[sbq[0].id] = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (rst && tag_v) begin
            chk("rsp_dbz", 32'(rsp_dbz), 32'(sbq[0].dbz));
            if (!sbq[0].dbz) begin
                chk("rsp_q", 32'(rsp_q), 32'(sbq[0].q));
                chk("rsp_r", 32'(rsp_r), 32'(sbq[0].r));
            end
        end

        acc = 0;
        win = 0;
        if (rst && !drain) begin
            for (int i = 0; i < NR; i++) begin
                if (!acc && req_valid[(ptr_m + i) % NR]) begin
                    acc = 1;
                    win = (ptr_m + i) % NR;
                end
            end
        end
        exp_ready = '0;
        if (acc) exp_ready[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("div_i_valid", 32'(div_i_valid), 32'(acc));
        a_w = req_a[win*DW +: DW];
        b_w = req_b[win*DW +: DW];
        if (acc) begin
            chk("div_a", 32'(div_a), 32'(a_w));
            chk("div_b", 32'(div_b), 32'(b_w));
        end

        if (!rst) begin
            sbq.delete();
            ptr_m   = 0;
            idle_m  = 1'b0;
            err_m   = 1'b0;
            warm_m  = L;
            started = 1;
        end else begin
            if (tag_v) void'(sbq.pop_front());
            if (acc) begin
                e.id  = win;
                e.due = cyc + L;
                e.dbz = (b_w == '0);
                e.q   = e.dbz ? '0 : a_w / b_w;
                e.r   = e.dbz ? '0 : a_w % b_w;
                sbq.push_back(e);
                ptr_m = (win + 1) % NR;
            end
            if (warm_m != 0) warm_m--;
            else if (div_o_valid != tag_v) err_m = 1'b1;
            idle_m = drain && (sbq.size() == 0);
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    initial begin
        bit got_idle;
        rst       = 1'b0;
        drain     = 1'b0;
        force_ov  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        step(2);
        rst = 1'b1;
        step(1);

        // Single op: 100 / 7 from requester 1
        set_req(1, 8'd100, 8'd7);
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        step(2);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("single_q", 32'(rsp_q), 32'd14);
        chk("single_r", 32'(rsp_r), 32'd2);
        step(3);

        // All four requesting every cycle
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++) set_req(i, 8'($urandom), 8'($urandom_range(1, 255)));
            step(1);
        end
        req_valid = '0;
        step(5);

        // Divide by zero from requester 2
        set_req(2, 8'd55, 8'd0);
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        step(5);

        // Drain with three in flight
        for (int i = 0; i < NR; i++) set_req(i, 8'(200 + i), 8'(3 + i));
        req_valid = 4'hF;
        step(3);
        drain = 1'b1;
        #1;
        chk("drain_ready", 32'(req_ready), 32'h0);
        got_idle = 0;
        for (int k = 0; k < 10 && !got_idle; k++) begin
            step(1);
            got_idle = idle;
        end
        chk("idle_reached", 32'(got_idle), 32'h1);
        drain     = 1'b0;
        req_valid = '0;
        step(2);

        // Reset with two in flight
        req_valid = 4'b0011;
        step(2);
        req_valid = '0;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(8);

        // Divider valid with no tag after warm-up
        force_ov = 1'b1;
        step(1);
        force_ov = 1'b0;
        step(4);
        chk("err_sticky", 32'(err), 32'h1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(4);

        // Random traffic with occasional drain
        for (int c = 0; c < 60; c++) begin
            req_valid = 4'($urandom);
            drain     = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NR; i++)
                set_req(i, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
            step(1);
        end
        req_valid = '0;
        drain     = 1'b0;
        step(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
